// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX/MEM pipeline register with writeback/memory decode, branch
//            resolution and an overflow trap state machine.
// Revision : 1.0  initial release
// ============================================================================
module ex_mem_stage #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    input  logic [31:0] store_data,
    input  logic [31:0] pc_plus4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic        out_wb_en,
    output logic [4:0]  out_wb_reg,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        trap,
    input  logic        trap_ack,
    output logic [31:0] retired_count
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_XORI  = 6'b001110;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_out_valid;
    logic [31:0] r_out_result;
    logic [31:0] r_out_store_data;
    logic        r_out_wb_en;
    logic [4:0]  r_out_wb_reg;
    logic        r_out_mem_read;
    logic        r_out_mem_write;
    logic        r_branch_taken;
    logic [31:0] r_branch_target;
    logic [31:0] r_retired_count;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_is_imm;
    logic        w_ovf;
    logic        w_br_cond;
    logic [4:0]  w_dst;
    logic        w_wb_en;
    logic        w_mem_read;
    logic        w_mem_write;
    logic [31:0] w_br_offset;
    logic        w_accept;
    logic        w_release;
    logic        w_unused;

    assign w_opcode    = instruction[31:26];
    assign w_funct     = instruction[5:0];
    assign w_is_imm    = (w_opcode >= c_OP_ADDI) && (w_opcode <= c_OP_XORI);
    assign w_br_offset = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign w_unused    = ^{instruction[25:21], alu_flags[1]};

    always_comb begin
        w_dst       = instruction[20:16];
        w_wb_en     = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_br_cond   = 1'b0;
        w_ovf       = 1'b0;
        if (w_opcode == c_OP_RTYPE) begin
            w_dst   = instruction[15:11];
            w_wb_en = 1'b1;
            w_ovf   = alu_flags[0] && ((w_funct == c_FN_ADD) || (w_funct == c_FN_SUB));
        end else if (w_is_imm) begin
            w_wb_en = 1'b1;
            w_ovf   = alu_flags[0] && (w_opcode == c_OP_ADDI);
        end else if (w_opcode == c_OP_LW) begin
            w_wb_en    = 1'b1;
            w_mem_read = 1'b1;
        end else if (w_opcode == c_OP_SW) begin
            w_mem_write = 1'b1;
        end else if (w_opcode == c_OP_BEQ) begin
            w_br_cond = alu_flags[2];
        end else if (w_opcode == c_OP_BNE) begin
            w_br_cond = !alu_flags[2];
        end
        // A trapping instruction must leave no architectural side effects
        if (w_ovf) begin
            w_wb_en     = 1'b0;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
        end
        if (w_dst == 5'd0) begin
            w_wb_en = 1'b0;
        end
    end

    assign in_ready  = (r_state == ST_RUN) && (!r_out_valid || out_ready) && !reset;
    assign w_accept  = in_valid && in_ready;
    assign w_release = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (w_accept && w_ovf) w_state_next = ST_TRAP;
            ST_TRAP: if (trap_ack)          w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_out_result     <= 32'd0;
            r_out_store_data <= 32'd0;
            r_out_wb_en      <= 1'b0;
            r_out_wb_reg     <= 5'd0;
            r_out_mem_read   <= 1'b0;
            r_out_mem_write  <= 1'b0;
            r_branch_taken   <= 1'b0;
            r_branch_target  <= 32'd0;
            r_retired_count  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_out_valid      <= 1'b1;
                r_out_result     <= alu_result;
                r_out_store_data <= store_data;
                r_out_wb_en      <= w_wb_en;
                r_out_wb_reg     <= w_dst;
                r_out_mem_read   <= w_mem_read;
                r_out_mem_write  <= w_mem_write;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
            r_branch_taken <= w_accept && (w_ovf || w_br_cond);
            if (w_accept && w_ovf) begin
                r_branch_target <= EXC_VECTOR;
            end else if (w_accept && w_br_cond) begin
                r_branch_target <= pc_plus4 + w_br_offset;
            end
            if (w_release) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_result     = r_out_result;
    assign out_store_data = r_out_store_data;
    assign out_wb_en      = r_out_wb_en;
    assign out_wb_reg     = r_out_wb_reg;
    assign out_mem_read   = r_out_mem_read;
    assign out_mem_write  = r_out_mem_write;
    assign branch_taken   = r_branch_taken;
    assign branch_target  = r_branch_target;
    assign trap           = (r_state == ST_TRAP);
    assign retired_count  = r_retired_count;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Directed and randomized checks of ex_mem_stage against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

    localparam logic [31:0] c_EXC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic [31:0] store_data;
    logic [31:0] pc_plus4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic        out_wb_en;
    logic [4:0]  out_wb_reg;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap;
    logic        trap_ack;
    logic [31:0] retired_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.EXC_VECTOR(c_EXC)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction    (instruction),
        .alu_result     (alu_result),
        .alu_flags      (alu_flags),
        .store_data     (store_data),
        .pc_plus4       (pc_plus4),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_wb_en      (out_wb_en),
        .out_wb_reg     (out_wb_reg),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .trap           (trap),
        .trap_ack       (trap_ack),
        .retired_count  (retired_count)
    );

    typedef struct packed {
        logic       wb;
        logic [4:0] dst;
        logic       mrd;
        logic       mwr;
        logic       br;
        logic       ovf;
    } exp_t;

    // Reference model: what the stage should be presenting after each edge
    logic        m_valid;
    logic        m_trap;
    logic        m_br;
    logic [31:0] m_tgt;
    logic [31:0] m_cnt;
    logic [31:0] m_res;
    logic [31:0] m_sd;
    exp_t        m_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [2:0] fl);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        e  = '0;
        case (op)
            6'h00: begin
                e.wb = 1'b1; e.dst = ins[15:11];
                e.ovf = fl[0] && (fn == 6'h20 || fn == 6'h22);
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                e.wb = 1'b1; e.dst = ins[20:16];
                e.ovf = fl[0] && (op == 6'h08);
            end
            6'h23: begin e.wb = 1'b1; e.dst = ins[20:16]; e.mrd = 1'b1; end
            6'h2B: e.mwr = 1'b1;
            6'h04: e.br = fl[2];
            6'h05: e.br = !fl[2];
            default: ;
        endcase
        if (e.ovf) begin e.wb = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0; end
        if (e.dst == 5'd0) e.wb = 1'b0;
        return e;
    endfunction

    function automatic logic m_ready();
        return !reset && !m_trap && (!m_valid || out_ready);
    endfunction

    task automatic model_edge();
        logic acc;
        logic rel;
        exp_t e;
        if (reset) begin
            m_valid = 1'b0; m_trap = 1'b0; m_br = 1'b0; m_tgt = '0;
            m_cnt = '0; m_res = '0; m_sd = '0; m_e = '0;
        end else begin
            acc = in_valid && m_ready();
            rel = m_valid && out_ready;
            e   = ref_decode(instruction, alu_flags);
            if (rel) m_cnt = m_cnt + 32'd1;
            if (m_trap && trap_ack) m_trap = 1'b0;
            m_br = acc && (e.br || e.ovf);
            if (acc && e.ovf) begin
                m_tgt  = c_EXC;
                m_trap = 1'b1;
            end else if (acc && e.br) begin
                m_tgt = pc_plus4 + (32'($signed(instruction[15:0])) * 32'd4);
            end
            if (acc) begin
                m_valid = 1'b1; m_e = e; m_res = alu_result; m_sd = store_data;
            end else if (rel) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("trap", 32'(trap), 32'(m_trap));
        chk("retired_count", retired_count, m_cnt);
        chk("branch_taken", 32'(branch_taken), 32'(m_br));
        chk("branch_target", branch_target, m_tgt);
        if (m_valid) begin
            chk("out_result", out_result, m_res);
            chk("out_store_data", out_store_data, m_sd);
            chk("out_wb_en", 32'(out_wb_en), 32'(m_e.wb));
            chk("out_mem_read", 32'(out_mem_read), 32'(m_e.mrd));
            chk("out_mem_write", 32'(out_mem_write), 32'(m_e.mwr));
            if (m_e.wb) chk("out_wb_reg", 32'(out_wb_reg), 32'(m_e.dst));
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [6];
        logic [5:0] ops [9];
        fns = '{6'h20, 6'h22, 6'h21, 6'h23, 6'h25, 6'h2A};
        ops = '{6'h08, 6'h09, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0F, 6'h02};
        case ($urandom_range(0, 3))
            0:       return mk_r(fns[$urandom_range(0, 5)], 5'($urandom), 5'($urandom), 5'($urandom));
            3:       return $urandom;
            default: return mk_i(ops[$urandom_range(0, 8)], 5'($urandom), 5'($urandom), 16'($urandom));
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; instruction = '0; alu_result = '0;
        alu_flags = '0; store_data = '0; pc_plus4 = '0; out_ready = 1'b1; trap_ack = 1'b0;
        m_valid = 1'b0; m_trap = 1'b0; m_br = 1'b0; m_tgt = '0;
        m_cnt = '0; m_res = '0; m_sd = '0; m_e = '0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_retired", retired_count, 32'd0);
        reset = 1'b0;
        step();

        // add $3 = 7
        in_valid = 1'b1; instruction = mk_r(6'h20, 5'd1, 5'd2, 5'd3);
        alu_result = 32'd7; alu_flags = 3'b000; store_data = 32'h1234;
        step();
        chk("add_wb_en", 32'(out_wb_en), 32'd1);
        chk("add_wb_reg", 32'(out_wb_reg), 32'd3);
        chk("add_result", out_result, 32'd7);
        in_valid = 1'b0;
        step();
        chk("add_retired", retired_count, 32'd1);

        // four back-to-back ori
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instruction = mk_i(6'h0D, 5'd4, 5'(i + 8), 16'(i));
            alu_result = 32'(100 + i);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("ori_stream_retired", retired_count, 32'd5);

        // stall for three cycles with the stream still offered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instruction = mk_i(6'h23, 5'd1, 5'(i + 12), 16'(i * 4));
            alu_result = 32'(200 + i); store_data = 32'(300 + i);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instruction = mk_i(6'h2B, 5'd1, 5'(i + 16), 16'(i));
            alu_result = 32'(400 + i);
            step();
        end
        in_valid = 1'b0;
        step();

        // beq taken with negative offset, then bne not taken
        in_valid = 1'b1; instruction = mk_i(6'h04, 5'd1, 5'd2, 16'hFFFF);
        pc_plus4 = 32'h100; alu_flags = 3'b100;
        step();
        chk("beq_pulse", 32'(branch_taken), 32'd1);
        chk("beq_target", branch_target, 32'h0000_00FC);
        in_valid = 1'b0;
        step();
        chk("beq_pulse_end", 32'(branch_taken), 32'd0);
        in_valid = 1'b1; instruction = mk_i(6'h05, 5'd1, 5'd2, 16'hFFFF);
        step();
        chk("bne_no_pulse", 32'(branch_taken), 32'd0);

        // addi overflow trap
        instruction = mk_i(6'h08, 5'd1, 5'd5, 16'h0001); alu_flags = 3'b001;
        step();
        chk("ovf_wb_en", 32'(out_wb_en), 32'd0);
        chk("ovf_target", branch_target, c_EXC);
        chk("ovf_trap", 32'(trap), 32'd1);
        alu_flags = 3'b000;
        instruction = mk_i(6'h0D, 5'd1, 5'd6, 16'h0002);
        for (int i = 0; i < 3; i++) step();
        trap_ack = 1'b1; in_valid = 1'b0;
        step();
        trap_ack = 1'b0;
        step();
        chk("trap_cleared", 32'(trap), 32'd0);

        // write to $0, then reset while holding a bundle
        in_valid = 1'b1; instruction = mk_i(6'h0D, 5'd1, 5'd0, 16'h00FF);
        step();
        chk("zero_reg_wb_en", 32'(out_wb_en), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_retired", retired_count, 32'd0);
        chk("post_rst_trap", 32'(trap), 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 99) < 2);
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 7);
            trap_ack    = ($urandom_range(0, 9) < 3);
            instruction = rand_instr();
            alu_result  = $urandom;
            alu_flags   = 3'($urandom);
            store_data  = $urandom;
            pc_plus4    = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
